// File: rtl/serial_tx_piso_pkg.sv
// Shared definitions for the serial_tx_piso framed transmitter.
package serial_tx_piso_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StPar   = 3'd3,
        StStop  = 3'd4
    } state_t;

    localparam int unsigned DefaultWidth = 8;
    localparam logic        IdleLevel    = 1'b1;

endpackage

// File: rtl/serial_tx_piso_bit_counter.sv
// Data-bit counter: synchronous clear/enable, terminal count flags index W-1.
module serial_tx_piso_bit_counter
    import serial_tx_piso_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] TermCount = CntW'(W - 1);

    logic [CntW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CntW'(1);
        end
    end

    assign o_tc = (r_count == TermCount);

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out framed transmitter: start, W data bits LSB first, stop.
// Define PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx_piso
    import serial_tx_piso_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         c,
    input  logic         re,
    input  logic [W-1:0] d,
    input  logic         ld,
    output logic         so,
    output logic         busy,
    output logic         done
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_shift;
    logic [W-1:0]   w_shift_nxt;
    logic [W-1:0]   w_neigh;
    logic           w_load;
    logic           w_tc;

    assign w_load = (r_state == StIdle) && ld;

    serial_tx_piso_bit_counter #(
        .W (W)
    ) u_bit_counter (
        .i_clk (c),
        .i_clr (re || w_load),
        .i_en  (r_state == StData),
        .o_tc  (w_tc)
    );

    // Each stage: 2:1 mux between load data and the right-hand neighbour.
    for (genvar i = 0; i < W; i++) begin : g_stage
        if (i == W - 1) begin : g_msb
            assign w_neigh[i] = 1'b0;
        end else begin : g_mid
            assign w_neigh[i] = r_shift[i+1];
        end
        assign w_shift_nxt[i] = w_load ? d[i] : w_neigh[i];
    end

    always_ff @(posedge c) begin
        if (re) begin
            r_shift <= '0;
        end else if (w_load || (r_state == StData)) begin
            r_shift <= w_shift_nxt;
        end
    end

`ifdef PARITY_EN
    logic r_par;

    // Captured at load so later changes on d cannot alter the parity bit.
    always_ff @(posedge c) begin
        if (re) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^d;
        end
    end
`endif

    always_ff @(posedge c) begin
        if (re) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (ld) w_state_nxt = StStart;
            StStart: w_state_nxt = StData;
`ifdef PARITY_EN
            StData:  if (w_tc) w_state_nxt = StPar;
            StPar:   w_state_nxt = StStop;
`else
            StData:  if (w_tc) w_state_nxt = StStop;
`endif
            StStop:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Outputs decode registered state only; ld and d never reach them directly.
    always_comb begin
        so   = IdleLevel;
        busy = 1'b1;
        done = 1'b0;
        case (r_state)
            StIdle:  busy = 1'b0;
            StStart: so = 1'b0;
            StData:  so = r_shift[0];
`ifdef PARITY_EN
            StPar:   so = r_par;
`endif
            StStop:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule
